freq_meas_sequencer: RTL

//  Sequences one frequency measurement: opens a gate window of GATE_CYCLES clk cycles and counts rising edges of sigClk.

---
 rtl/freq_meas_pkg.sv | 38 +++
 rtl/freq_meas_sequencer_sig_edge_sync.sv | 41 ++++
 rtl/freq_meas_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/freq_meas_pkg.sv
// -----------------------------------------------------------------------------
// freq_meas_pkg
// Shared definitions for the frequency measurement sequencer: FSM state
// encoding, Status codes, frame header bytes and small frame helpers.
// -----------------------------------------------------------------------------
package freq_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GATE    = 3'd1,
        ST_LATCH   = 3'd2,
        ST_LOAD    = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_WAIT_LO = 3'd5
    } state_t;

    localparam logic [1:0] STATUS_IDLE = 2'b00;
    localparam logic [1:0] STATUS_GATE = 2'b01;
    localparam logic [1:0] STATUS_SEND = 2'b10;
    localparam logic [1:0] STATUS_OVF  = 2'b11;

    localparam logic [7:0] HDR_OK  = 8'hA5;
    localparam logic [7:0] HDR_OVF = 8'hAE;

    // Cycles to wait for BUSY to rise before a byte is assumed sent.
    localparam logic [1:0] BUSY_WAIT_LAST = 2'd3;

    // Status code shown while a frame is being sent.
    function automatic logic [1:0] send_status(input logic ovf);
        return ovf ? STATUS_OVF : STATUS_SEND;
    endfunction

    // Header byte that opens a frame.
    function automatic logic [7:0] frame_header(input logic ovf);
        return ovf ? HDR_OVF : HDR_OK;
    endfunction

endpackage

// File: rtl/freq_meas_sequencer_sig_edge_sync.sv
// -----------------------------------------------------------------------------
// sig_edge_sync
// Brings an asynchronous input into the clk domain through a 2-flop
// synchronizer and emits a registered one-cycle pulse per rising edge.
// The pulse appears 3 clk cycles after the input edge.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   i_async  in  1  asynchronous input
//   o_rise   out 1  one-cycle rising-edge pulse (registered)
// -----------------------------------------------------------------------------
module sig_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_rise;

    // Synchronizer chain, edge-detect history flop and registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/freq_meas_sequencer.sv
// -----------------------------------------------------------------------------
// freq_meas_sequencer
// Opens a gate window of GATE_CYCLES clk cycles, counts rising edges of
// sigClk, latches the result and streams a framed result (header byte, then
// NBYTES count bytes MSB first) to an SPI master over data/sendEnable/BUSY.
// Ports:
//   clk         in   1      system clock
//   rst         in   1      synchronous active-high reset
//   sigClk      in   1      measured signal, asynchronous to clk
//   start       in   1      measurement request (only when CONTINUOUS=0)
//   BUSY        in   1      SPI master busy
//   data        out  8      byte to transmit, valid with sendEnable
//   sendEnable  out  1      one-cycle load strobe
//   Status      out  2      00 idle, 01 gate, 10 send, 11 overflow send
//   count       out  CNT_W  last latched edge count
// -----------------------------------------------------------------------------
module freq_meas_sequencer
    import freq_meas_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 32,
    parameter int NBYTES      = 4,
    parameter int CONTINUOUS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sigClk,
    input  logic             start,
    input  logic             BUSY,
    output logic [7:0]       data,
    output logic             sendEnable,
    output logic [1:0]       Status,
    output logic [CNT_W-1:0] count
);

    localparam int GW      = $clog2(GATE_CYCLES + 1);
    localparam int BW      = $clog2(NBYTES + 1);
    localparam int FRAME_W = 8 * (NBYTES + 1);

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES);

    state_t               r_state;
    logic [GW-1:0]        r_gate_cnt;
    logic [CNT_W-1:0]     r_edge_cnt;
    logic                 r_ovf;
    logic [FRAME_W-1:0]   r_frame;
    logic [BW-1:0]        r_byte_idx;
    logic [1:0]           r_wait_cnt;
    logic [7:0]           r_data;
    logic                 r_send;
    logic [1:0]           r_status;
    logic [CNT_W-1:0]     r_count;

    logic                 w_edge;
    logic                 w_sat_hit;
    logic                 w_byte_done;

    sig_edge_sync u_sig_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sigClk),
        .o_rise  (w_edge)
    );

    // An edge arriving while the counter is already all-ones is an overflow.
    assign w_sat_hit = w_edge & (&r_edge_cnt);

    // A byte is finished when BUSY drops after rising, or never rose in time.
    assign w_byte_done = ((r_state == ST_WAIT_HI) && !BUSY && (r_wait_cnt == BUSY_WAIT_LAST)) ||
                         ((r_state == ST_WAIT_LO) && !BUSY);

    // Measurement and frame transmit sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_frame    <= '0;
            r_byte_idx <= '0;
            r_wait_cnt <= 2'd0;
            r_data     <= 8'h00;
            r_send     <= 1'b0;
            r_status   <= STATUS_IDLE;
            r_count    <= '0;
        end else begin
            r_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if ((CONTINUOUS != 0) || start) begin
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf      <= 1'b0;
                        r_status   <= STATUS_GATE;
                        r_state    <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    if (w_sat_hit) begin
                        r_ovf <= 1'b1;
                    end else if (w_edge) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                    if (r_gate_cnt == GATE_LAST) begin
                        // Include an overflow from this final gate cycle.
                        r_status <= send_status(r_ovf | w_sat_hit);
                        r_state  <= ST_LATCH;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    r_count    <= r_edge_cnt;
                    r_frame    <= {frame_header(r_ovf), r_edge_cnt};
                    r_byte_idx <= '0;
                    r_state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!BUSY) begin
                        // Frame is shifted out from the top byte down.
                        r_data     <= r_frame[FRAME_W-1 -: 8];
                        r_frame    <= r_frame << 8;
                        r_send     <= 1'b1;
                        r_wait_cnt <= 2'd0;
                        r_state    <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (BUSY) begin
                        r_state <= ST_WAIT_LO;
                    end else if (r_wait_cnt != BUSY_WAIT_LAST) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    r_state <= ST_WAIT_LO;
                end
                default: begin
                    r_status <= STATUS_IDLE;
                    r_state  <= ST_IDLE;
                end
            endcase

            if (w_byte_done) begin
                if (r_byte_idx == BYTE_LAST) begin
                    r_status <= STATUS_IDLE;
                    r_state  <= ST_IDLE;
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    r_state    <= ST_LOAD;
                end
            end
        end
    end

    assign data       = r_data;
    assign sendEnable = r_send;
    assign Status     = r_status;
    assign count      = r_count;

endmodule
